// File: rtl/audio_stream_bridge.sv
// audio_stream_bridge: buffered bridge between the Audio_Controller sample interface and the
// effects core's valid/ready streams, all in the CLOCK_50 domain.
//   CLOCK_50, reset_n               : clock, async active-low reset (sync release)
//   audio_in_available/read_audio_in: codec capture handshake, codec_in (ch0 in LSBs)
//   audio_out_allowed/write_audio_out: codec playback handshake, codec_out (registered)
//   core_in_*                       : show-ahead stream of truncated frames to the core
//   core_out_*                      : stream of frames from the core into the output FIFO
//   mode                            : 0/3 normal, 1 bypass, 2 mute
//   clear_flags, overflow, underflow: sticky status (a set beats a clear)
//   in_level, out_level             : FIFO occupancy in frames
module audio_stream_bridge #(
  parameter int unsigned SAMPLE_W   = 32,
  parameter int unsigned CORE_W     = 24,
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                             CLOCK_50,
  input  logic                             reset_n,
  input  logic                             audio_in_available,
  input  logic                             audio_out_allowed,
  output logic                             read_audio_in,
  output logic                             write_audio_out,
  input  logic [NUM_CH*SAMPLE_W-1:0]       codec_in,
  output logic [NUM_CH*SAMPLE_W-1:0]       codec_out,
  output logic                             core_in_valid,
  input  logic                             core_in_ready,
  output logic [NUM_CH*CORE_W-1:0]         core_in_data,
  input  logic                             core_out_valid,
  output logic                             core_out_ready,
  input  logic [NUM_CH*CORE_W-1:0]         core_out_data,
  input  logic [1:0]                       mode,
  input  logic                             clear_flags,
  output logic                             overflow,
  output logic                             underflow,
  output logic [$clog2(FIFO_DEPTH):0]      in_level,
  output logic [$clog2(FIFO_DEPTH):0]      out_level
);

  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam int unsigned PW  = AW + 1;
  localparam int unsigned PAD = SAMPLE_W - CORE_W;
  localparam int unsigned CFW = NUM_CH * CORE_W;
  localparam int unsigned SFW = NUM_CH * SAMPLE_W;
  localparam logic [1:0] ModeBypass = 2'd1;
  localparam logic [1:0] ModeMute   = 2'd2;

  typedef enum logic [1:0] {CapIdle, CapRead, CapGap} cap_state_e;
  typedef enum logic [1:0] {PbIdle, PbWrite, PbGap} pb_state_e;

  cap_state_e cap_state_q, cap_state_d;
  pb_state_e  pb_state_q, pb_state_d;
  logic       cap_bypass_q, cap_bypass_d;
  logic [SFW-1:0] codec_out_q, codec_out_d;
  logic       primed_q, overflow_q, overflow_d, underflow_q, underflow_d;

  logic [CFW-1:0] in_mem_q  [FIFO_DEPTH];
  logic [CFW-1:0] out_mem_q [FIFO_DEPTH];
  logic [PW-1:0]  in_wr_q, in_rd_q, out_wr_q, out_rd_q;

  logic in_empty, in_full, out_empty, out_full;
  logic cap_to_in, cap_to_out, in_push, in_pop;
  logic out_push_cap, out_push_core, out_push, pb_start, ovf_set, unf_set;
  logic [CFW-1:0] cap_frame, out_head, out_wdata;
  logic [SFW-1:0] head_up;

  // Truncate each codec word to its top CORE_W bits; widen back left-justified with zero fill.
  always_comb begin
    cap_frame = '0;
    head_up   = '0;
    out_head  = out_mem_q[out_rd_q[AW-1:0]];
    for (int c = 0; c < NUM_CH; c++) begin
      cap_frame[c*CORE_W +: CORE_W]        = codec_in[c*SAMPLE_W + PAD +: CORE_W];
      head_up[c*SAMPLE_W + PAD +: CORE_W]  = out_head[c*CORE_W +: CORE_W];
    end
  end

  // FIFO status: pointers carry a wrap bit above the index.
  assign in_empty  = (in_wr_q == in_rd_q);
  assign in_full   = (in_wr_q[AW] != in_rd_q[AW]) && (in_wr_q[AW-1:0] == in_rd_q[AW-1:0]);
  assign out_empty = (out_wr_q == out_rd_q);
  assign out_full  = (out_wr_q[AW] != out_rd_q[AW]) && (out_wr_q[AW-1:0] == out_rd_q[AW-1:0]);
  assign in_level  = in_wr_q - in_rd_q;
  assign out_level = out_wr_q - out_rd_q;

  // Capture lands on the edge that ends the READ cycle; destination chosen when leaving IDLE.
  assign cap_to_in  = (cap_state_q == CapRead) && !cap_bypass_q;
  assign cap_to_out = (cap_state_q == CapRead) && cap_bypass_q;

  assign core_in_valid = !in_empty && (mode != ModeBypass);
  assign core_in_data  = in_mem_q[in_rd_q[AW-1:0]];
  assign in_pop        = core_in_valid && core_in_ready;
  // A full FIFO still accepts a frame when the head leaves in the same cycle.
  assign in_push       = cap_to_in && (!in_full || in_pop);

  // The core is held off whenever the capture path owns the output FIFO write port.
  assign core_out_ready = reset_n && !out_full && (mode != ModeBypass) && !cap_to_out;
  assign pb_start       = (pb_state_q == PbIdle) && audio_out_allowed && !out_empty;
  assign out_push_cap   = cap_to_out && (!out_full || pb_start);
  assign out_push_core  = core_out_valid && core_out_ready;
  assign out_push       = out_push_cap || out_push_core;
  assign out_wdata      = cap_to_out ? cap_frame : core_out_data;

  assign ovf_set = (cap_to_in && !in_push) || (cap_to_out && !out_push_cap);
  assign unf_set = (pb_state_q == PbIdle) && audio_out_allowed && out_empty && primed_q;

  always_comb begin
    overflow_d  = ovf_set | (overflow_q & ~clear_flags);
    underflow_d = unf_set | (underflow_q & ~clear_flags);
  end

  // Capture FSM: state register, next state, outputs.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      cap_state_q  <= CapIdle;
      cap_bypass_q <= 1'b0;
    end else begin
      cap_state_q  <= cap_state_d;
      cap_bypass_q <= cap_bypass_d;
    end
  end

  always_comb begin
    cap_state_d  = cap_state_q;
    cap_bypass_d = cap_bypass_q;
    case (cap_state_q)
      CapIdle: begin
        if (audio_in_available) begin
          cap_state_d  = CapRead;
          cap_bypass_d = (mode == ModeBypass);
        end
      end
      CapRead: cap_state_d = CapGap;
      CapGap:  cap_state_d = CapIdle;
      default: cap_state_d = CapIdle;
    endcase
  end

  always_comb begin
    read_audio_in = (cap_state_q == CapRead);
  end

  // Playback FSM: the head frame is popped and registered on the IDLE->WRITE edge.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      pb_state_q  <= PbIdle;
      codec_out_q <= '0;
    end else begin
      pb_state_q  <= pb_state_d;
      codec_out_q <= codec_out_d;
    end
  end

  always_comb begin
    pb_state_d  = pb_state_q;
    codec_out_d = codec_out_q;
    case (pb_state_q)
      PbIdle: begin
        if (pb_start) begin
          pb_state_d  = PbWrite;
          codec_out_d = (mode == ModeMute) ? '0 : head_up;
        end
      end
      PbWrite: pb_state_d = PbGap;
      PbGap:   pb_state_d = PbIdle;
      default: pb_state_d = PbIdle;
    endcase
  end

  always_comb begin
    write_audio_out = (pb_state_q == PbWrite);
    codec_out       = codec_out_q;
    overflow        = overflow_q;
    underflow       = underflow_q;
  end

  // FIFO storage, pointers and sticky status.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      in_wr_q     <= '0;
      in_rd_q     <= '0;
      out_wr_q    <= '0;
      out_rd_q    <= '0;
      primed_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        in_mem_q[i]  <= '0;
        out_mem_q[i] <= '0;
      end
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      if (pb_start) primed_q <= 1'b1;
      if (in_push) begin
        in_mem_q[in_wr_q[AW-1:0]] <= cap_frame;
        in_wr_q <= in_wr_q + PW'(1);
      end
      if (in_pop) in_rd_q <= in_rd_q + PW'(1);
      if (out_push) begin
        out_mem_q[out_wr_q[AW-1:0]] <= out_wdata;
        out_wr_q <= out_wr_q + PW'(1);
      end
      if (pb_start) out_rd_q <= out_rd_q + PW'(1);
    end
  end

endmodule

// File: tb/tb_audio_stream_bridge.sv
module tb_audio_stream_bridge;
  localparam int SW = 32;
  localparam int CW = 24;
  localparam int NC = 2;
  localparam int D  = 8;
  localparam int PAD = SW - CW;

  logic clk = 1'b0;
  logic rst_n;
  logic audio_in_available, audio_out_allowed, read_audio_in, write_audio_out;
  logic [NC*SW-1:0] codec_in, codec_out;
  logic core_in_valid, core_in_ready, core_out_valid, core_out_ready;
  logic [NC*CW-1:0] core_in_data, core_out_data;
  logic [1:0] mode;
  logic clear_flags, overflow, underflow;
  logic [3:0] in_level, out_level;

  audio_stream_bridge #(.SAMPLE_W(SW), .CORE_W(CW), .NUM_CH(NC), .FIFO_DEPTH(D)) dut (
    .CLOCK_50(clk), .reset_n(rst_n),
    .audio_in_available(audio_in_available), .audio_out_allowed(audio_out_allowed),
    .read_audio_in(read_audio_in), .write_audio_out(write_audio_out),
    .codec_in(codec_in), .codec_out(codec_out),
    .core_in_valid(core_in_valid), .core_in_ready(core_in_ready), .core_in_data(core_in_data),
    .core_out_valid(core_out_valid), .core_out_ready(core_out_ready),
    .core_out_data(core_out_data), .mode(mode), .clear_flags(clear_flags),
    .overflow(overflow), .underflow(underflow), .in_level(in_level), .out_level(out_level)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;

  // Scoreboards and reference state.
  logic [NC*CW-1:0] exp_core_q[$];
  logic [NC*SW-1:0] exp_codec_q[$];
  logic [NC*SW-1:0] src_q[$];
  logic [NC*CW-1:0] loop_q[$];
  bit src_pend, loop_en, rnd, exp_ovf;
  int src_prob, src_limit, gen_cnt;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Codec word -> core word keeps the top CW bits.
  function automatic logic [NC*CW-1:0] to_core(input logic [NC*SW-1:0] f);
    logic [NC*CW-1:0] r;
    logic [SW-1:0] w;
    r = '0;
    for (int c = 0; c < NC; c++) begin
      w = f[c*SW +: SW];
      r[c*CW +: CW] = CW'(w >> PAD);
    end
    return r;
  endfunction

  // Core word -> codec word, left-justified.
  function automatic logic [NC*SW-1:0] to_codec(input logic [NC*CW-1:0] f);
    logic [NC*SW-1:0] r;
    logic [SW-1:0] w;
    r = '0;
    for (int c = 0; c < NC; c++) begin
      w = SW'(f[c*CW +: CW]);
      r[c*SW +: SW] = w << PAD;
    end
    return r;
  endfunction

  function automatic bit tb_idle();
    return exp_core_q.size() == 0 && exp_codec_q.size() == 0 && src_q.size() == 0 &&
           loop_q.size() == 0 && !src_pend && gen_cnt == 0 && !core_out_valid;
  endfunction

  task automatic monitor();
    logic [NC*CW-1:0] ec;
    logic [NC*SW-1:0] eo;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (read_audio_in) rd_cnt++;
        if (core_in_valid && core_in_ready) begin
          check("core_in frame expected", 64'(exp_core_q.size() != 0), 64'd1);
          if (exp_core_q.size() != 0) begin
            ec = exp_core_q.pop_front();
            check("core_in_data", 64'(core_in_data), 64'(ec));
          end
        end
        if (write_audio_out) begin
          wr_cnt++;
          check("codec_out frame expected", 64'(exp_codec_q.size() != 0), 64'd1);
          if (exp_codec_q.size() != 0) begin
            eo = exp_codec_q.pop_front();
            check("codec_out", codec_out, eo);
          end
        end
      end
    end
  endtask

  // One clock: observe handshakes at negedge, update stimulus 1 unit after posedge.
  task automatic step();
    logic took, out_x;
    logic [NC*SW-1:0] f;
    @(negedge clk);
    took  = read_audio_in;
    out_x = core_out_valid && core_out_ready;
    if (core_in_valid && core_in_ready && loop_en) loop_q.push_back(core_in_data);
    @(posedge clk);
    #1;
    if (took) begin
      src_pend = 1'b0;
      audio_in_available = 1'b0;
    end
    if (out_x) core_out_valid = 1'b0;
    if (!core_out_valid) begin
      if (loop_q.size() != 0) begin
        core_out_data  = loop_q.pop_front();
        core_out_valid = 1'b1;
      end else if (gen_cnt != 0) begin
        core_out_data  = {NC{24'h7FFFFF}};
        core_out_valid = 1'b1;
        gen_cnt--;
        exp_codec_q.push_back(mode == 2'd2 ? '0 : to_codec({NC{24'h7FFFFF}}));
      end
    end
    if (!src_pend && src_q.size() != 0 && exp_core_q.size() < src_limit &&
        $urandom_range(99) < src_prob) begin
      f = src_q.pop_front();
      codec_in = f;
      audio_in_available = 1'b1;
      src_pend = 1'b1;
      if (mode == 2'd1) exp_codec_q.push_back(to_codec(to_core(f)));
      else if (exp_core_q.size() < D) begin
        exp_core_q.push_back(to_core(f));
        if (loop_en) exp_codec_q.push_back(mode == 2'd2 ? '0 : to_codec(to_core(f)));
      end else exp_ovf = 1'b1;
    end
    if (rnd) begin
      core_in_ready     = ($urandom_range(99) < 70);
      audio_out_allowed = ($urandom_range(99) < 50);
      mode              = ($urandom_range(1) == 0) ? 2'd0 : 2'd3;
    end
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (!tb_idle() && n < 600) begin
      step();
      n++;
    end
    check({tag, " drained"}, 64'(tb_idle()), 64'd1);
    repeat (3) step();
  endtask

  task automatic pulse_clear();
    clear_flags = 1'b1;
    step();
    clear_flags = 1'b0;
  endtask

  initial begin
    int n, rd0, wr0;
    bit leak, cor;
    rst_n = 1'b0; audio_in_available = 1'b0; audio_out_allowed = 1'b0; codec_in = '0;
    core_in_ready = 1'b0; core_out_valid = 1'b0; core_out_data = '0; mode = 2'd0;
    clear_flags = 1'b0; src_pend = 0; loop_en = 0; rnd = 0; exp_ovf = 0;
    src_prob = 100; src_limit = 100; gen_cnt = 0;
    fork
      monitor();
    join_none

    // Reset values.
    #12;
    check("rst core_out_ready low", 64'(core_out_ready), 64'd0);
    check("rst strobes", 64'({read_audio_in, write_audio_out}), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("core_out_ready after rst", 64'(core_out_ready), 64'd1);
    check("core_in valid/data after rst", 64'({core_in_valid, core_in_data}), 64'd0);
    check("codec_out after rst", codec_out, 64'd0);
    check("levels/flags after rst", 64'({in_level, out_level, overflow, underflow}), 64'd0);

    // Directed passthrough with capture latency.
    loop_en = 1; rd0 = rd_cnt; wr0 = wr_cnt;
    src_q.push_back(64'hFFFFFF01_12345678);
    step();
    n = 0;
    while (!core_in_valid && n < 10) begin
      step();
      n++;
    end
    check("capture latency", 64'(n), 64'd2);
    check("truncated frame", 64'(core_in_data), 64'h0000_FFFFFF_123456);
    core_in_ready = 1'b1; audio_out_allowed = 1'b1;
    drain("passthrough");
    check("passthrough codec_out", codec_out, 64'hFFFFFF00_12345600);
    check("passthrough reads", 64'(rd_cnt - rd0), 64'd1);
    check("passthrough writes", 64'(wr_cnt - wr0), 64'd1);

    // Randomized looped-back traffic in modes 0/3.
    rd0 = rd_cnt; wr0 = wr_cnt;
    for (int i = 0; i < 40; i++) src_q.push_back({$urandom, $urandom});
    rnd = 1; src_prob = 60; src_limit = 5;
    n = 0;
    while (src_q.size() != 0 && n < 3000) begin
      step();
      n++;
    end
    rnd = 0; core_in_ready = 1'b1; audio_out_allowed = 1'b1; mode = 2'd0;
    drain("random");
    check("random reads", 64'(rd_cnt - rd0), 64'd40);
    check("random writes", 64'(wr_cnt - wr0), 64'd40);
    check("random overflow", 64'(overflow), 64'(exp_ovf));

    // Overflow: core stalled, 10 frames into an 8-deep FIFO.
    pulse_clear();
    loop_en = 0; core_in_ready = 1'b0; src_prob = 100; src_limit = 100; rd0 = rd_cnt;
    for (int i = 0; i < 8; i++) src_q.push_back({$urandom, $urandom});
    n = 0;
    while ((rd_cnt - rd0) < 8 && n < 100) begin
      step();
      n++;
    end
    repeat (3) step();
    check("ovf level at 8", 64'(in_level), 64'd8);
    check("ovf not yet", 64'(overflow), 64'(exp_ovf));
    for (int i = 0; i < 2; i++) src_q.push_back({$urandom, $urandom});
    n = 0;
    while ((rd_cnt - rd0) < 10 && n < 100) begin
      step();
      n++;
    end
    repeat (3) step();
    check("ovf reads", 64'(rd_cnt - rd0), 64'd10);
    check("ovf level saturated", 64'(in_level), 64'd8);
    check("ovf set", 64'(overflow), 64'(exp_ovf));
    pulse_clear();
    exp_ovf = 0;
    check("ovf cleared", 64'(overflow), 64'(exp_ovf));
    core_in_ready = 1'b1;
    drain("overflow");

    // Bypass: capture goes straight to playback.
    mode = 2'd1; audio_out_allowed = 1'b1; rd0 = rd_cnt; wr0 = wr_cnt; leak = 0; cor = 0;
    for (int i = 0; i < 4; i++) src_q.push_back({$urandom, $urandom});
    n = 0;
    while (!tb_idle() && n < 200) begin
      step();
      leak |= core_in_valid;
      cor |= core_out_ready;
      n++;
    end
    repeat (3) step();
    check("bypass core_in_valid", 64'(leak), 64'd0);
    check("bypass core_out_ready", 64'(cor), 64'd0);
    check("bypass reads", 64'(rd_cnt - rd0), 64'd4);
    check("bypass writes", 64'(wr_cnt - wr0), 64'd4);

    // Mute: core frames are consumed, codec gets zeros.
    mode = 2'd2; audio_out_allowed = 1'b0; wr0 = wr_cnt; gen_cnt = 3;
    repeat (10) step();
    check("mute out_level", 64'(out_level), 64'd3);
    audio_out_allowed = 1'b1;
    step();
    check("playback latency strobe", 64'(write_audio_out), 64'd1);
    check("mute out_level dec", 64'(out_level), 64'd2);
    drain("mute");
    check("mute writes", 64'(wr_cnt - wr0), 64'd3);
    check("mute out_level empty", 64'(out_level), 64'd0);

    // Reset in the READ cycle.
    mode = 2'd0; audio_out_allowed = 1'b0; core_in_ready = 1'b0; gen_cnt = 1;
    repeat (4) step();
    check("pre-reset out_level", 64'(out_level), 64'd1);
    src_q.push_back({$urandom, $urandom});
    n = 0;
    while (!read_audio_in && n < 20) begin
      step();
      n++;
    end
    check("read strobe reached", 64'(read_audio_in), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("reset kills read strobe", 64'(read_audio_in), 64'd0);
    check("reset levels", 64'({in_level, out_level}), 64'd0);
    check("reset flags", 64'({overflow, underflow}), 64'd0);
    check("reset core_out_ready", 64'(core_out_ready), 64'd0);
    exp_core_q.delete(); exp_codec_q.delete(); loop_q.delete();
    src_pend = 0; audio_in_available = 1'b0; core_out_valid = 1'b0; gen_cnt = 0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Underflow only once primed.
    audio_out_allowed = 1'b1; core_in_ready = 1'b1;
    repeat (6) step();
    check("underflow before prime", 64'(underflow), 64'd0);
    gen_cnt = 1;
    drain("underflow");
    check("underflow frame", codec_out, 64'h7FFFFF00_7FFFFF00);
    check("underflow set", 64'(underflow), 64'd1);
    clear_flags = 1'b1;
    step();
    check("set wins over clear", 64'(underflow), 64'd1);
    audio_out_allowed = 1'b0;
    step();
    clear_flags = 1'b0;
    check("underflow cleared", 64'(underflow), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/audio_stream_bridge.md
# audio_stream_bridge

Parametrised, buffered bridge between the Audio_Controller sample interface (available/allowed strobes, per-channel 32-bit words) and the effects core's valid/ready streams. It replaces the direct wiring in the DE1-SoC wrapper. It adds frame FIFOs in both directions, codec/core width conversion, N-channel support, bypass/mute modes and sticky overflow/underflow reporting. It sits between `Audio_Controller` and `top`, in the `CLOCK_50` domain.

## Interface
- SAMPLE_W, 32, codec word width per channel
- CORE_W, 24, core sample width per channel (CORE_W <= SAMPLE_W)
- NUM_CH, 2, channels per frame (ch0 = left, ch1 = right)
- FIFO_DEPTH, 8, frames per FIFO (power of 2, >= 2)

Ports:
- CLOCK_50  in  1  sole clock
- reset_n  in  1  asynchronous, active-low reset
- audio_in_available  in  1  codec has an input frame
- audio_out_allowed  in  1  codec can accept an output frame
- read_audio_in  out  1  one-cycle pop strobe to codec
- write_audio_out  out  1  one-cycle push strobe to codec
- codec_in  in  NUM_CH*SAMPLE_W  input frame, ch0 in LSBs
- codec_out  out  NUM_CH*SAMPLE_W  output frame, ch0 in LSBs
- core_in_valid / core_in_ready  out / in  1  stream to core
- core_in_data  out  NUM_CH*CORE_W  frame to core
- core_out_valid / core_out_ready  in / out  1  stream from core
- core_out_data  in  NUM_CH*CORE_W  frame from core
- mode  in  2  0 normal, 1 bypass, 2 mute, 3 treated as normal
- clear_flags  in  1  synchronous clear of sticky flags
- overflow, underflow  out  1  sticky status
- in_level, out_level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy

## Operation
- Capture FSM, states IDLE → READ → GAP → IDLE.
  - IDLE→READ when audio_in_available = 1.
  - READ: assert read_audio_in for exactly one cycle and sample codec_in on that edge.
  - GAP: one cycle with no strobe, so the codec's available flag can update.
- Down-conversion: per channel, core word = codec word[SAMPLE_W-1 -: CORE_W]. This is truncation, with no rounding.
- Routing of captured frames:
  - normal/mute: push into the input FIFO.
  - bypass: push into the output FIFO.
  - Destination full: the frame is still read and then discarded, and overflow is set. The codec is never stalled.
- Input FIFO read side:
  - core_in_valid = !empty, and core_in_data = head frame (show-ahead).
  - A pop occurs on core_in_valid && core_in_ready.
  - In bypass, core_in_valid is forced to 0.
- Output FIFO write side:
  - core_out_ready = !full, and is forced to 0 in bypass.
  - A push occurs on core_out_valid && core_out_ready.
  - In bypass, the capture path has priority and is the only writer.
- Playback FSM, states IDLE → WRITE → GAP → IDLE.
  - IDLE→WRITE when audio_out_allowed && output FIFO not empty.
  - WRITE: codec_out is registered from the head frame, and write_audio_out asserts for one cycle while that frame is popped.
- Up-conversion: codec word = {core word, (SAMPLE_W-CORE_W) zeros}, which is left-justified.
- Mute: frames are consumed normally, but codec_out is all zeros.
- Underflow: sets when audio_out_allowed = 1 and the output FIFO is empty in IDLE, after at least one frame has been written since reset (primed).
- Sticky flags:
  - clear_flags clears both flags.
  - A set event in the same cycle as clear_flags wins (flag reads 1).
- Mode is sampled only in IDLE of the relevant FSM, so a frame in flight is never split across modes.
- Bypass→normal switch: frames already in the output FIFO drain normally. The input FIFO is not flushed.
- FIFO pointers carry an extra wrap bit. Full = same index with the wrap bit differing. Empty = pointers equal. Simultaneous push and pop on a full or empty FIFO are both legal and leave the level unchanged, except that a pop on empty and a push on full are blocked.

## Timing
- Reset (async assert, sync release): FSMs in IDLE, FIFOs empty, primed = 0. All outputs are 0: strobes, codec_out, core_in_valid, core_in_data, flags and levels. core_out_ready is 1 after reset since the FIFO is not full (0 while reset_n is low).
- Reset asserted mid-frame aborts the operation immediately. No strobe is emitted after reset_n falls.
- Capture latency: audio_in_available high at edge k → read_audio_in high in cycle k+1 → frame visible on core_in_data at k+2. Maximum rate is one frame per 3 cycles per direction.
- Playback latency: audio_out_allowed high with the FIFO non-empty at edge k → write_audio_out and codec_out valid in cycle k+1.
- Capture and playback FSMs are independent and may strobe in the same cycle.

## Test plan
- Normal passthrough, CORE_W=24: codec_in ch0=0x12345678, ch1=0xFFFFFF01. The core sees 0x123456 and 0xFFFFFF. With the core looped back, codec_out = 0x12345600 and 0xFFFFFF00. Exactly one read_audio_in pulse and one write_audio_out pulse.
- Overflow: hold core_in_ready=0 with FIFO_DEPTH=8 and deliver 10 frames. in_level saturates at 8 and overflow rises on the 9th read. All 10 read pulses still occur. clear_flags clears overflow.
- Bypass: mode=1 and 4 input frames. core_in_valid stays 0, and codec_out reproduces each frame with the low 8 bits zeroed, in order.
- Mute: mode=2 with the core producing 0x7FFFFF. write_audio_out pulses occur with codec_out = 0, and out_level decrements.
- Underflow: write 1 frame, then hold audio_out_allowed=1 with the FIFO empty. underflow sets once primed, but not before the first frame.
- Reset mid-operation: drop reset_n in the READ cycle. read_audio_in falls immediately, and all levels and flags read 0.
